// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared instruction-memory sizing and loader state encoding
package mips_pkg;

  localparam int IMEM_DEPTH = 64;
  localparam int IMEM_AW    = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3,
    ERROR   = 3'd4
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-serial loader that writes big-endian words into instruction memory
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = IMEM_AW,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  loader_state_t     state;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        byte_cnt;
  logic [31:0]       shift;
  logic              last_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr       <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      last_q     <= 1'b0;
      word_count <= '0;
      checksum   <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            addr       <= '0;
            byte_cnt   <= '0;
            shift      <= '0;
            last_q     <= 1'b0;
            word_count <= '0;
            checksum   <= '0;
            state      <= COLLECT;
          end
        end
        COLLECT: begin
          // in_ready is high throughout COLLECT, so in_valid alone marks a transfer
          if (in_valid) begin
            shift    <= {shift[23:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              last_q <= in_last;
              state  <= WRITE;
            end else if (in_last) begin
              state <= ERROR;
            end
          end
        end
        WRITE: begin
          checksum   <= checksum ^ shift;
          word_count <= word_count + (ADDR_W+1)'(1);
          addr       <= addr + ADDR_W'(1);
          if (last_q)                 state <= DONE;
          else if (addr == LAST_ADDR) state <= ERROR;
          else                        state <= COLLECT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from registered state only; nothing passes straight from the inputs
  assign in_ready   = (state == COLLECT);
  assign imem_we    = (state == WRITE);
  assign imem_waddr = addr;
  assign imem_wdata = shift;
  assign cpu_hold   = (state == COLLECT) || (state == WRITE) || (state == ERROR);
  assign done       = (state == DONE);
  assign error      = (state == ERROR);

endmodule

// File: doc/imem_loader.md
# imem_loader

Writes a program into the MIPS instruction memory from a byte-serial stream, so the processor can be reprogrammed without a `memfile.dat` rebuild. It assembles incoming bytes big-endian into 32-bit instruction words and issues one write per word starting at word address 0. It holds the processor stalled while loading and reports completion, word count and an XOR checksum. It sits between the host/debug byte source and the write port of the instruction memory.

## Interface
Parameters:
- `ADDR_W`, 6: instruction memory word-address width, which matches the 6-bit instruction read address.
- `DEPTH`, 64: number of instruction words; must equal 2**ADDR_W.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  single-cycle request to begin a load.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_last`  in  1  marks the final byte of the program; qualified by `in_valid`.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction memory write enable; one-cycle pulse per word.
- `imem_waddr`  out  ADDR_W  word address being written.
- `imem_wdata`  out  32  instruction word being written.
- `cpu_hold`  out  1  stall/hold request to the pipeline while loading or in error.
- `done`  out  1  load completed successfully.
- `error`  out  1  load aborted (partial word or overflow).
- `word_count`  out  ADDR_W+1  words written in the current or last load, range 0..64.
- `checksum`  out  32  XOR of all words written in the current or last load.

## Operation
- A byte transfers when `in_valid && in_ready` are both high. `in_data` and `in_last` are sampled only at that edge.
- Byte order is big-endian. The first byte of a word goes to [31:24], the fourth to [7:0].
- The state machine is `mips_pkg::loader_state_t` with five states:
  - IDLE:
    - `in_ready`=0 and `cpu_hold`=0.
    - On `start`, clear the address, byte counter, `word_count`, `checksum`, `done` and `error`, then go to COLLECT.
  - COLLECT:
    - `in_ready`=1 and `cpu_hold`=1.
    - Each accepted byte is shifted in and the byte counter (2 bits) increments.
    - The 4th byte goes to WRITE, and the value of `in_last` on that byte is latched.
    - `in_last` on bytes 1–3 goes to ERROR (partial word); nothing is written.
  - WRITE:
    - `in_ready`=0 and `imem_we`=1 for exactly one cycle, with `imem_waddr`=current address and `imem_wdata`=assembled word.
    - In the same edge, `checksum` ^= word, `word_count`++ and the address increments.
    - Next state:
      - latched last → DONE;
      - else address was DEPTH-1 → ERROR (overflow);
      - else → COLLECT.
  - DONE:
    - `done`=1, `cpu_hold`=0 and `in_ready`=0.
    - `start` restarts the load as from IDLE.
  - ERROR:
    - `error`=1, `cpu_hold`=1 and `in_ready`=0.
    - Only `start` or reset exits this state; `start` restarts the load as from IDLE.
- `start` is ignored in COLLECT and WRITE.
- The address wraps modulo DEPTH internally. The overflow check above means a wrapped address is never written.
- A program of exactly 64 words whose final byte carries `in_last` ends in DONE with `word_count`=64.

## Timing
- Reset value of every output is 0: `in_ready`, `imem_we`, `imem_waddr`, `imem_wdata`, `cpu_hold`, `done`, `error`, `word_count`, `checksum`. State resets to IDLE.
- Reset applied mid-load returns to IDLE on the next edge. The partial word is discarded and no write is issued.
- `in_ready` rises the cycle after `start` is sampled.
- `imem_we` is asserted in the cycle immediately after the edge that accepts the 4th byte, so write latency is 1 cycle.
- `in_ready` is 0 in that cycle. Peak throughput is 4 bytes per 5 cycles.
- `done` or `error` is asserted the cycle after the final WRITE cycle, or the cycle after a partial-word `in_last` is accepted.
- `word_count` and `checksum` update at the WRITE edge and are stable in DONE/ERROR until the next `start`.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Structure
- `mips_pkg` holds:
  - `loader_state_t`, an enum with IDLE, COLLECT, WRITE, DONE and ERROR;
  - `IMEM_DEPTH` = 64;
  - `IMEM_AW` = 6.
- The instruction memory read port also uses `IMEM_DEPTH` and `IMEM_AW`.
- The design is a single module. The byte-to-word shift register is kept inline; no sub-module is required.

## Test plan
- **Nominal load:**
  - Stimulus: `start`, then bytes for 0x20020005, 0x2003000c, 0x2067fff7, with `in_last` on byte 12.
  - Response: writes at addresses 0, 1, 2 with those exact words; `done`=1; `word_count`=3; `checksum`=0x2066fffe; `cpu_hold` falls with `done`.
- **Backpressure and gaps:**
  - Stimulus: the same program with `in_valid` toggled randomly.
  - Response: identical writes and checksum; `in_ready`=0 during every `imem_we` cycle.
- **Partial word:**
  - Stimulus: 6 bytes with `in_last` on byte 6.
  - Response: one write at address 0, then `error`=1, `cpu_hold`=1, `word_count`=1 and no second write.
- **Boundary:**
  - 64 words with `in_last` on byte 256: `done`=1 and `word_count`=64.
  - 65 words: `error` after the write to address 63, and no write to address 0.
- **Reset mid-load:** deassert `reset_n` for one cycle after 2 bytes of word 1. Response: all outputs 0 and no `imem_we`; a subsequent `start` plus one word writes at address 0.
- **Ignored restart:** pulse `start` in COLLECT. Response: no clear; the load continues to the same `word_count` and `checksum`.
